// File: rtl/alu4_bist.sv
// Exhaustive self-test sequencer for a 4-bit ALU: sweeps every op/A/B vector,
// compares each response against a built-in golden model and records the outcome.
module alu4_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_Y,
    input  logic       alu_carry_out,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_sign,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [10:0] err_count,
    output logic [2:0] first_fail_op,
    output logic [3:0] first_fail_A,
    output logic [3:0] first_fail_B,
    output logic [4:0] first_fail_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [3:0] settle_cnt;
    logic       settle_hit;
    logic       launch;
    logic       step;
    logic       last_vec;

    logic [4:0] sum5;
    logic [4:0] diff5;
    logic [3:0] gold_y;
    logic       gold_c;
    logic       gold_o;
    logic [4:0] field_mask;
    logic       mismatch;

    always_comb begin
        sum5   = {1'b0, alu_A} + {1'b0, alu_B};
        diff5  = {1'b0, alu_A} - {1'b0, alu_B};
        gold_y = 4'd0;
        gold_c = 1'b0;
        gold_o = 1'b0;
        case (alu_op)
            3'd0: begin
                gold_y = sum5[3:0];
                gold_c = sum5[4];
                gold_o = ~(alu_A[3] ^ alu_B[3]) & (sum5[3] ^ alu_A[3]);
            end
            3'd1: begin
                gold_y = diff5[3:0];
                gold_c = ~diff5[4];
                gold_o = (alu_A[3] ^ alu_B[3]) & (diff5[3] ^ alu_A[3]);
            end
            3'd2:    gold_y = alu_A & alu_B;
            3'd3:    gold_y = alu_A | alu_B;
            3'd4:    gold_y = alu_A ^ alu_B;
            default: gold_y = 4'd0;
        endcase
    end

    // Field order {Y, C, OVF, Z, S}
    assign field_mask = {(alu_Y != gold_y),
                         (alu_carry_out != gold_c),
                         (alu_overflow != gold_o),
                         (alu_zero != (gold_y == 4'd0)),
                         (alu_sign != gold_y[3])};
    assign mismatch   = |field_mask;

    assign settle_hit = (settle_cnt == 4'(SETTLE_CYCLES - 1));
    assign last_vec   = (alu_op == 3'd4) && (alu_A == 4'hF) && (alu_B == 4'hF);
    assign busy       = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_hit) begin
                    step = 1'b1;
                    if (last_vec) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op          <= 3'd0;
            alu_A           <= 4'd0;
            alu_B           <= 4'd0;
            settle_cnt      <= 4'd0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 11'd0;
            first_fail_op   <= 3'd0;
            first_fail_A    <= 4'd0;
            first_fail_B    <= 4'd0;
            first_fail_mask <= 5'd0;
        end else if (launch) begin
            alu_op          <= 3'd0;
            alu_A           <= 4'd0;
            alu_B           <= 4'd0;
            settle_cnt      <= 4'd0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 11'd0;
            first_fail_op   <= 3'd0;
            first_fail_A    <= 4'd0;
            first_fail_B    <= 4'd0;
            first_fail_mask <= 5'd0;
        end else if (state == RUN) begin
            if (abort) begin
                // Partial error data stays visible for post-mortem
                settle_cnt <= 4'd0;
                done       <= 1'b0;
                pass       <= 1'b0;
            end else begin
                settle_cnt <= settle_hit ? 4'd0 : settle_cnt + 4'd1;
                if (step) begin
                    if (mismatch) begin
                        err_count <= err_count + 11'd1;
                        if (err_count == 11'd0) begin
                            first_fail_op   <= alu_op;
                            first_fail_A    <= alu_A;
                            first_fail_B    <= alu_B;
                            first_fail_mask <= field_mask;
                        end
                    end
                    if (last_vec) begin
                        done <= 1'b1;
                        pass <= (err_count == 11'd0) && !mismatch;
                    end else if (alu_B != 4'hF) begin
                        alu_B <= alu_B + 4'd1;
                    end else begin
                        alu_B <= 4'd0;
                        if (alu_A != 4'hF) begin
                            alu_A <= alu_A + 4'd1;
                        end else begin
                            alu_A  <= 4'd0;
                            alu_op <= alu_op + 3'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu4_bist.sv
// Bench for alu4_bist: behavioural ALU with injectable faults, sweep-result scoreboard.
module tb_alu4_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic [1:0] fault_mode = 2'd0;

    logic [3:0] a1, b1, y1, a3, b3, y3;
    logic [2:0] op1, op3;
    logic c1, o1, z1, s1, c3, o3, z3, s3;
    logic busy1, done1, pass1, busy3, done3, pass3;
    logic [10:0] err1, err3;
    logic [2:0] ffop1, ffop3;
    logic [3:0] ffa1, ffb1, ffa3, ffb3;
    logic [4:0] ffm1, ffm3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] err;
        logic [4:0]  mask;
        logic [2:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        pass;
        int          cycles;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Reference ALU written with signed integer ranges; result packed {Y,C,OVF,Z,S}
    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sbv, r, sr;
        logic [3:0] y;
        logic c, o;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 7) ? ia - 16 : ia;
        sbv = (ib > 7) ? ib - 16 : ib;
        c = 1'b0;
        o = 1'b0;
        y = 4'd0;
        case (op)
            3'd0: begin r = ia + ib; y = 4'(r); c = (r > 15); sr = sa + sbv; o = (sr > 7) || (sr < -8); end
            3'd1: begin r = ia - ib; y = 4'(r); c = (ia >= ib); sr = sa - sbv; o = (sr > 7) || (sr < -8); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            default: y = 4'd0;
        endcase
        return {y, c, o, (y == 4'd0), y[3]};
    endfunction

    // 1: Y[0] stuck-at-0, 2: carry inverted on SUB only
    function automatic logic [7:0] apply_fault(input logic [1:0] mode, input logic [2:0] op, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (mode == 2'd1) r[4] = 1'b0;
        if (mode == 2'd2 && op == 3'd1) r[3] = ~r[3];
        return r;
    endfunction

    logic [7:0] raw1, flt1, reg1, drv1, raw3, reg3;
    assign raw1 = alu_model(op1, a1, b1);
    assign flt1 = apply_fault(fault_mode, op1, raw1);
    always_ff @(posedge clk) reg1 <= flt1;
    assign drv1 = (fault_mode == 2'd3) ? reg1 : flt1;
    assign {y1, c1, o1, z1, s1} = drv1;

    assign raw3 = alu_model(op3, a3, b3);
    always_ff @(posedge clk) reg3 <= raw3;
    assign {y3, c3, o3, z3, s3} = reg3;

    alu4_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .alu_A(a1), .alu_B(b1), .alu_op(op1),
        .alu_Y(y1), .alu_carry_out(c1), .alu_overflow(o1), .alu_zero(z1), .alu_sign(s1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_op(ffop1), .first_fail_A(ffa1), .first_fail_B(ffb1), .first_fail_mask(ffm1)
    );

    alu4_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .alu_A(a3), .alu_B(b3), .alu_op(op3),
        .alu_Y(y3), .alu_carry_out(c3), .alu_overflow(o3), .alu_zero(z3), .alu_sign(s3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_op(ffop3), .first_fail_A(ffa3), .first_fail_B(ffb3), .first_fail_mask(ffm3)
    );

    task automatic predict(input logic [1:0] mode, input int cycles);
        exp_t e;
        logic [7:0] r, f;
        logic [4:0] m;
        e.err = 11'd0; e.mask = 5'd0; e.op = 3'd0; e.a = 4'd0; e.b = 4'd0;
        for (int op = 0; op < 5; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    r = alu_model(3'(op), 4'(a), 4'(b));
                    f = apply_fault(mode, 3'(op), r);
                    m = {|(r[7:4] ^ f[7:4]), r[3] ^ f[3], r[2] ^ f[2], r[1] ^ f[1], r[0] ^ f[0]};
                    if (m != 5'd0) begin
                        if (e.err == 11'd0) begin
                            e.mask = m; e.op = 3'(op); e.a = 4'(a); e.b = 4'(b);
                        end
                        e.err = e.err + 11'd1;
                    end
                end
        e.pass = (e.err == 11'd0);
        e.cycles = cycles;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic wait_done1(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done1) begin ok = 1'b1; break; end
            if (busy1) cycles++;
            @(negedge clk);
        end
    endtask

    // Scoreboard consumer: pops the predicted sweep outcome and compares dut1 against it
    task automatic sb_check_sweep(input string name, input int cycles, input bit ok);
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL %s done_timeout: got done=%0b required 1", name, done1); end
        checks++;
        if (cycles !== e.cycles) begin errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, cycles, e.cycles); end
        checks++;
        if (err1 !== e.err) begin errors++; $display("FAIL %s err_count: got %0d required %0d", name, err1, e.err); end
        checks++;
        if (pass1 !== e.pass || busy1 !== 1'b0) begin errors++; $display("FAIL %s pass/busy: got %0b/%0b required %0b/0", name, pass1, busy1, e.pass); end
        checks++;
        if ({ffop1, ffa1, ffb1, ffm1} !== {e.op, e.a, e.b, e.mask})
            begin errors++; $display("FAIL %s first_fail: got op=%0d A=%0d B=%0d mask=%b required op=%0d A=%0d B=%0d mask=%b", name, ffop1, ffa1, ffb1, ffm1, e.op, e.a, e.b, e.mask); end
        checks++;
        if ({op1, a1, b1} !== {3'd4, 4'hF, 4'hF}) begin errors++; $display("FAIL %s hold_last_vec: got op=%0d A=%0d B=%0d required 4/15/15", name, op1, a1, b1); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy1, done1, pass1, err1, ffop1, ffa1, ffb1, ffm1, op1, a1, b1} !== '0 ||
            {busy3, done3, pass3, err3, ffop3, ffa3, ffb3, ffm3, op3, a3, b3} !== '0)
            begin errors++; $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0d op=%0d A=%0d B=%0d required all 0", busy1, done1, err1, op1, a1, b1); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean;
        int cyc; bit ok;
        fault_mode = 2'd0;
        predict(2'd0, 1280);
        pulse_start1;
        wait_done1(cyc, ok);
        sb_check_sweep("clean", cyc, ok);
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1) begin errors++; $display("FAIL clean_done_pass: got %0b/%0b required 1/1", done1, pass1); end
    endtask

    task automatic test_stuck_y0;
        int cyc; bit ok;
        fault_mode = 2'd1;
        predict(2'd1, 1280);
        pulse_start1;
        wait_done1(cyc, ok);
        sb_check_sweep("stuck_y0", cyc, ok);
        checks++;
        if (err1 !== 11'd640 || ffm1 !== 5'b10000) begin errors++; $display("FAIL stuck_y0_const: got err=%0d mask=%b required 640/10000", err1, ffm1); end
    endtask

    task automatic test_carry_sub;
        int cyc; bit ok;
        fault_mode = 2'd2;
        predict(2'd2, 1280);
        pulse_start1;
        wait_done1(cyc, ok);
        sb_check_sweep("carry_sub", cyc, ok);
        checks++;
        if (err1 !== 11'd256 || ffop1 !== 3'd1 || ffm1 !== 5'b01000) begin errors++; $display("FAIL carry_sub_const: got err=%0d op=%0d mask=%b required 256/1/01000", err1, ffop1, ffm1); end
    endtask

    task automatic test_latency;
        int cyc; bit ok;
        cyc = 0; ok = 1'b0;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (done3) begin ok = 1'b1; break; end
            if (busy3) cyc++;
            @(negedge clk);
        end
        checks++;
        if (!ok || cyc !== 3840) begin errors++; $display("FAIL latency_s3_cycles: got %0d (done=%0b) required 3840", cyc, done3); end
        checks++;
        if (pass3 !== 1'b1 || err3 !== 11'd0) begin errors++; $display("FAIL latency_s3_pass: got pass=%0b err=%0d required 1/0", pass3, err3); end
        fault_mode = 2'd3;
        pulse_start1;
        wait_done1(cyc, ok);
        checks++;
        if (!ok || pass1 !== 1'b0 || err1 === 11'd0) begin errors++; $display("FAIL latency_s1_fails: got done=%0b pass=%0b err=%0d required 1/0/nonzero", done1, pass1, err1); end
    endtask

    task automatic test_restart_abort;
        int cyc; bit ok;
        fault_mode = 2'd0;
        predict(2'd0, 1280);
        pulse_start1;
        repeat (100) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(cyc, ok);
        sb_check_sweep("restart_ignored", cyc + 101, ok);
        // abort with no sweep running changes nothing
        abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL abort_in_done: got done=%0b pass=%0b busy=%0b required 1/1/0", done1, pass1, busy1); end
        // start and abort together in DONE: start wins
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk) begin start1 = 1'b0; abort1 = 1'b0; end
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL start_beats_abort: got busy=%0b done=%0b required 1/0", busy1, done1); end
        repeat (500) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("FAIL abort_run: got busy=%0b done=%0b pass=%0b required 0/0/0", busy1, done1, pass1); end
        repeat (5) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || {op1, a1} === {3'd4, 4'hF}) begin errors++; $display("FAIL abort_stays_idle: got busy=%0b op=%0d required busy 0 and sweep halted", busy1, op1); end
        predict(2'd0, 1280);
        pulse_start1;
        wait_done1(cyc, ok);
        sb_check_sweep("after_abort", cyc, ok);
    endtask

    task automatic test_reset_midrun;
        int cyc; bit ok;
        fault_mode = 2'd1;
        pulse_start1;
        repeat (700) @(negedge clk);
        checks++;
        if (busy1 !== 1'b1 || err1 === 11'd0) begin errors++; $display("FAIL midrun_progress: got busy=%0b err=%0d required 1/nonzero", busy1, err1); end
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy1, done1, pass1, err1, ffop1, ffa1, ffb1, ffm1, op1, a1, b1} !== '0)
            begin errors++; $display("FAIL async_reset: got busy=%0b err=%0d op=%0d A=%0d B=%0d mask=%b required all 0", busy1, err1, op1, a1, b1, ffm1); end
        @(negedge clk) rst_n = 1'b1;
        predict(2'd1, 1280);
        pulse_start1;
        wait_done1(cyc, ok);
        sb_check_sweep("after_reset", cyc, ok);
        checks++;
        if (err1 !== 11'd640) begin errors++; $display("FAIL reset_no_accumulate: got %0d required 640", err1); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_stuck_y0;
        test_carry_sub;
        test_latency;
        test_restart_abort;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
